inst_mem_arbiter: RTL

Two-master arbiter sharing the single-port 8192x32 instruction memory between the processor instruction-fetch port and the program-loader port (host/boot download). Sits directly in front of the instruction RAM, drives its address/write/byte-enable/clock-enable pins, and routes each read return to the master that issued it. Fetch has priority. A starvation counter guarantees loader progress, and a lock input gives the loader exclusive ownership during program download.

---
 rtl/inst_mem_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/inst_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_mem_arbiter: fetch/loader arbiter for the shared instruction RAM     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module inst_mem_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 32,
  parameter int BE_W         = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_read,
  input  logic [ADDR_W-1:0] f_address,
  output logic              f_waitrequest,
  output logic [DATA_W-1:0] f_readdata,
  output logic              f_readdatavalid,
  input  logic              l_read,
  input  logic              l_write,
  input  logic [ADDR_W-1:0] l_address,
  input  logic [DATA_W-1:0] l_writedata,
  input  logic [BE_W-1:0]   l_byteenable,
  input  logic              l_lock,
  output logic              l_waitrequest,
  output logic [DATA_W-1:0] l_readdata,
  output logic              l_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic [1:0] {
    TAG_IDLE  = 2'd0,
    TAG_FETCH = 2'd1,
    TAG_LOAD  = 2'd2
  } tag_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0]        starve_cnt;
  logic              lock_r;
  tag_t              rd_tag;
  logic [ADDR_W-1:0] addr_r;

  logic l_req;
  logic f_gnt;
  logic l_gnt;

  assign l_req = l_read | l_write;

  // Grants are forced off during reset so the RAM sees no access.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!reset) begin
      if (lock_r) begin
        l_gnt = l_req;
      end else if (f_read && l_req) begin
        l_gnt = (starve_cnt == STARVE_MAX);
        f_gnt = ~l_gnt;
      end else begin
        f_gnt = f_read;
        l_gnt = l_req;
      end
    end
  end

  always_comb begin
    mem_address    = addr_r;
    mem_byteenable = {BE_W{1'b1}};
    if (f_gnt) begin
      mem_address = f_address;
    end else if (l_gnt) begin
      mem_address = l_address;
      if (l_write) begin
        mem_byteenable = l_byteenable;
      end
    end
  end

  assign mem_chipselect  = f_gnt | l_gnt;
  assign mem_write       = l_gnt & l_write;
  assign mem_writedata   = l_writedata;
  assign mem_clken       = ~reset;
  assign f_waitrequest   = ~f_gnt;
  assign l_waitrequest   = ~l_gnt;
  assign f_readdata      = mem_readdata;
  assign l_readdata      = mem_readdata;
  assign f_readdatavalid = (rd_tag == TAG_FETCH) & ~reset;
  assign l_readdatavalid = (rd_tag == TAG_LOAD) & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
      lock_r     <= 1'b0;
      rd_tag     <= TAG_IDLE;
      addr_r     <= '0;
    end else begin
      addr_r <= mem_address;

      if (f_gnt) begin
        rd_tag <= TAG_FETCH;
      end else if (l_gnt && l_read && !l_write) begin
        rd_tag <= TAG_LOAD;
      end else begin
        rd_tag <= TAG_IDLE;
      end

      // Lock waits for an in-flight fetch read to return before taking effect.
      if (!l_lock) begin
        lock_r <= 1'b0;
      end else if (rd_tag != TAG_FETCH) begin
        lock_r <= 1'b1;
      end

      if (lock_r || l_gnt) begin
        starve_cnt <= 4'd0;
      end else if (l_req && (starve_cnt != STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire
